// File: rtl/video_pattern_generator_pkg.sv
// Shared constants for the test-pattern generator: pattern codes, bar colours, box directions.
// Pure definitions, no logic; no flow control involved.
package video_pattern_pkg;

  localparam logic [2:0] PAT_BARS     = 3'd0;
  localparam logic [2:0] PAT_CHECKER  = 3'd1;
  localparam logic [2:0] PAT_GRADIENT = 3'd2;
  localparam logic [2:0] PAT_BOX      = 3'd3;
  localparam logic [2:0] PAT_SOLID    = 3'd4;

  // {red,green,blue}: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/video_pattern_generator_bounce_axis.sv
// Single-axis bouncing position: moves STEP per strobe, reflects at 0 and LIMIT-SIZE.
// Updates on the cycle after the strobe; no backpressure, strobe is never refused.
module bounce_axis
  import video_pattern_pkg::*;
#(
  parameter int LIMIT = 1280,
  parameter int SIZE  = 64,
  parameter int STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  output logic [11:0] pos
);

  // Increasing direction shares the DIR_RIGHT/DIR_DOWN encoding, decreasing shares DIR_LEFT/DIR_UP.
  logic        dir;
  logic        dir_next;
  logic [11:0] pos_next;
  logic [12:0] fwd_end;

  always_comb begin
    fwd_end  = {1'b0, pos} + 13'(STEP + SIZE);
    pos_next = pos;
    dir_next = dir;
    if (dir == DIR_RIGHT) begin
      if (fwd_end > 13'(LIMIT)) begin
        pos_next = 12'(LIMIT - SIZE);
        dir_next = DIR_LEFT;
      end else begin
        pos_next = pos + 12'(STEP);
      end
    end else begin
      if (pos < 12'(STEP)) begin
        pos_next = '0;
        dir_next = DIR_RIGHT;
      end else begin
        pos_next = pos - 12'(STEP);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos <= '0;
      dir <= DIR_RIGHT;
    end else if (step) begin
      pos <= pos_next;
      dir <= dir_next;
    end
  end

endmodule

// File: rtl/video_pattern_generator.sv
// RGB test-pattern source ahead of the DVI encoder; pattern and solid colour latched at vSync rise.
// Fixed 2-cycle latency on every output; no backpressure, one pixel accepted per clock.
module video_pattern_generator
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE      = 1280,
  parameter int V_ACTIVE      = 720,
  parameter int BAR_WIDTH     = 160,
  parameter int CHECKER_SHIFT = 5,
  parameter int GRAD_SHIFT    = 2,
  parameter int BOX_SIZE      = 64,
  parameter int BOX_STEP      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dataEnable,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [10:0] hPos,
  input  logic [10:0] vPos,
  input  logic [2:0]  patternSelect,
  input  logic [23:0] solidColor,
  output logic        dataEnableOut,
  output logic        hSyncOut,
  output logic        vSyncOut,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  logic        de1, hs1, vs1;
  logic [10:0] hpos1, vpos1;
  logic [2:0]  bar_idx1;
  logic [7:0]  bar_count;
  logic [2:0]  bar_index;
  logic [2:0]  active_pattern;
  logic [23:0] solid;
  logic [15:0] frame_count;
  logic [11:0] box_x, box_y;
  logic        frame_start;
  logic        in_box;
  logic [23:0] pix;

  // vs1 doubles as the previous-vSync register, so a long vSync pulse yields one event.
  assign frame_start = vSync & ~vs1;

  always_ff @(posedge clock) begin
    if (reset) begin
      de1            <= 1'b0;
      hs1            <= 1'b0;
      vs1            <= 1'b0;
      hpos1          <= '0;
      vpos1          <= '0;
      bar_idx1       <= '0;
      bar_count      <= '0;
      bar_index      <= '0;
      active_pattern <= PAT_BARS;
      solid          <= '0;
      frame_count    <= '0;
    end else begin
      de1      <= dataEnable;
      hs1      <= hSync;
      vs1      <= vSync;
      hpos1    <= hPos;
      vpos1    <= vPos;
      bar_idx1 <= bar_index;
      if (!dataEnable) begin
        bar_count <= '0;
        bar_index <= '0;
      end else if (bar_count == 8'(BAR_WIDTH - 1)) begin
        bar_count <= '0;
        if (bar_index != 3'd7) bar_index <= bar_index + 3'd1;
      end else begin
        bar_count <= bar_count + 8'd1;
      end
      if (frame_start) begin
        active_pattern <= patternSelect;
        solid          <= solidColor;
        frame_count    <= frame_count + 16'd1;
      end
    end
  end

  bounce_axis #(.LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_box_x (
    .clock (clock),
    .reset (reset),
    .step  (frame_start),
    .pos   (box_x)
  );

  bounce_axis #(.LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_box_y (
    .clock (clock),
    .reset (reset),
    .step  (frame_start),
    .pos   (box_y)
  );

  always_comb begin
    in_box = ({1'b0, hpos1} >= box_x) && ({1'b0, hpos1} < box_x + 12'(BOX_SIZE)) &&
             ({1'b0, vpos1} >= box_y) && ({1'b0, vpos1} < box_y + 12'(BOX_SIZE));
    pix = '0;
    case (active_pattern)
      PAT_BARS:     pix = BAR_COLORS[bar_idx1];
      PAT_CHECKER:  pix = (hpos1[CHECKER_SHIFT] ^ vpos1[CHECKER_SHIFT]) ? 24'h000000 : 24'hFFFFFF;
      PAT_GRADIENT: pix = {3{hpos1[GRAD_SHIFT+7:GRAD_SHIFT]}};
      PAT_BOX:      pix = in_box ? 24'h00FF00 : 24'h0000FF;
      PAT_SOLID:    pix = solid;
      default:      pix = '0;
    endcase
    if (!de1) pix = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dataEnableOut <= 1'b0;
      hSyncOut      <= 1'b0;
      vSyncOut      <= 1'b0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
    end else begin
      dataEnableOut       <= de1;
      hSyncOut            <= hs1;
      vSyncOut            <= vs1;
      {red, green, blue}  <= pix;
    end
  end

endmodule

// File: tb/tb_video_pattern_generator.sv
// Bench for video_pattern_generator: cycle-stepped stimulus scored against a frame-level model.
module tb_video_pattern_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dataEnable = 1'b0;
  logic        hSync = 1'b0;
  logic        vSync = 1'b0;
  logic [10:0] hPos = '0;
  logic [10:0] vPos = '0;
  logic [2:0]  patternSelect = '0;
  logic [23:0] solidColor = '0;
  logic        dataEnableOut, hSyncOut, vSyncOut;
  logic [7:0]  red, green, blue;

  video_pattern_generator dut (
    .clock         (clock),
    .reset         (reset),
    .dataEnable    (dataEnable),
    .hSync         (hSync),
    .vSync         (vSync),
    .hPos          (hPos),
    .vPos          (vPos),
    .patternSelect (patternSelect),
    .solidColor    (solidColor),
    .dataEnableOut (dataEnableOut),
    .hSyncOut      (hSyncOut),
    .vSyncOut      (vSyncOut),
    .red           (red),
    .green         (green),
    .blue          (blue)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Frame-level reference state
  int          m_prev_vs, m_pat, m_fc, m_bx, m_by, m_dx, m_dy, m_run;
  logic [23:0] m_solid;
  logic [26:0] exp_q[$];

  function automatic logic [23:0] model_color(int pat, int h, int v, int run);
    int idx;
    logic [7:0] g;
    case (pat)
      0: begin
        idx = run / 160;
        if (idx > 7) idx = 7;
        return {((idx == 0 || idx == 1 || idx == 4 || idx == 5) ? 8'hFF : 8'h00),
                ((idx <= 3) ? 8'hFF : 8'h00),
                ((idx % 2 == 0) ? 8'hFF : 8'h00)};
      end
      1: return ((((h / 32) + (v / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
      2: begin
        g = 8'((h / 4) % 256);
        return {g, g, g};
      end
      3: return (h >= m_bx && h < m_bx + 64 && v >= m_by && v < m_by + 64) ? 24'h00FF00 : 24'h0000FF;
      4: return m_solid;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic int bounce(input int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + 4 + 64 > lim) begin d = -1; return lim - 64; end
      return p + 4;
    end
    if (p < 4) begin d = 1; return 0; end
    return p - 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_prev_vs = 0; m_pat = 0; m_fc = 0; m_solid = '0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_run = 0;
    exp_q.delete();
    exp_q.push_back(27'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clock); #1;
      check("reset_out", 32'({dataEnableOut, hSyncOut, vSyncOut, red, green, blue}), 32'd0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [10:0] h, input logic [10:0] v);
    logic [23:0] col;
    dataEnable = de; hSync = hs; vSync = vs; hPos = h; vPos = v;
    if (vs && m_prev_vs == 0) begin
      m_pat = int'(patternSelect);
      m_solid = solidColor;
      m_fc = (m_fc + 1) % 65536;
      m_bx = bounce(m_bx, m_dx, 1280);
      m_by = bounce(m_by, m_dy, 720);
    end
    m_prev_vs = vs ? 1 : 0;
    col = de ? model_color(m_pat, int'(h), int'(v), m_run) : 24'h0;
    m_run = de ? m_run + 1 : 0;
    exp_q.push_back({de, hs, vs, col});
    @(posedge clock); #1;
    check("pixel_pipe", 32'({dataEnableOut, hSyncOut, vSyncOut, red, green, blue}),
          32'(exp_q.pop_front()));
  endtask

  task automatic vsync_pulse(input int len);
    repeat (len) step(1'b0, 1'b0, 1'b1, 11'd0, 11'd0);
    step(1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
  endtask

  task automatic line(input int w, input int v);
    for (int h = 0; h < w; h++) step(1'b1, 1'b0, 1'b0, 11'(h), 11'(v));
    step(1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    step(1'b0, 1'b1, 1'b0, 11'd0, 11'd0);
    step(1'b0, 1'b1, 1'b0, 11'd0, 11'd0);
    step(1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
  endtask

  initial begin
    int fc_before;
    model_reset();
    do_reset(3);

    // Full line of colour bars
    patternSelect = 3'd0;
    vsync_pulse(2);
    line(1280, 0);

    // Checkerboard, then reset mid-line with dataEnable high: bars resume from white
    patternSelect = 3'd1;
    vsync_pulse(1);
    for (int h = 0; h < 100; h++) step(1'b1, 1'b0, 1'b0, 11'(h), 11'd40);
    do_reset(3);
    for (int h = 103; h < 400; h++) step(1'b1, 1'b0, 1'b0, 11'(h), 11'd40);
    line(0, 0);

    // Pattern change mid-frame takes effect only at the next vSync rise
    patternSelect = 3'd0;
    vsync_pulse(1);
    line(200, 0);
    patternSelect = 3'd2;
    line(300, 1);
    vsync_pulse(1);
    line(1280, 0);

    // Checkerboard at random positions
    patternSelect = 3'd1;
    vsync_pulse(1);
    for (int i = 0; i < 200; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 11'($urandom), 11'($urandom));

    // Solid colour: blanked while dataEnable low, sync passes through aligned
    patternSelect = 3'd4;
    solidColor = 24'h123456;
    vsync_pulse(1);
    solidColor = 24'hABCDEF;
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 11'($urandom), 11'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 11'($urandom), 11'($urandom));

    // Unused pattern codes are black
    for (int p = 5; p < 8; p++) begin
      patternSelect = 3'(p);
      vsync_pulse(1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 11'($urandom), 11'($urandom));
    end

    // Long vSync pulse counts as one frame
    fc_before = m_fc;
    vsync_pulse(5);
    check("frame_count_once", 32'(dut.frame_count), 32'((fc_before + 1) % 65536));
    check("frame_count_model", 32'(dut.frame_count), 32'(m_fc));

    // Bouncing box over 400 frames, restarted from a clean reset
    do_reset(1);
    patternSelect = 3'd3;
    for (int f = 0; f < 400; f++) begin
      vsync_pulse(1);
      step(1'b1, 1'b0, 1'b0, 11'(m_bx), 11'(m_by));
      step(1'b1, 1'b0, 1'b0, 11'(m_bx + 64), 11'(m_by));
      step(1'b1, 1'b0, 1'b0, 11'(m_bx + 63), 11'(m_by + 63));
      step(1'b1, 1'b0, 1'b0, 11'(m_bx), 11'(m_by + 64));
      step(1'b1, 1'b0, 1'b0, 11'(m_bx - 1), 11'(m_by));
      step(1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
      if (f % 8 == 0 || f == 303 || f == 304 || f == 164 || f == 165) begin
        check("box_x", 32'(dut.u_box_x.pos), 32'(m_bx));
        check("box_y", 32'(dut.u_box_y.pos), 32'(m_by));
      end
    end

    // Randomised mix including occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 49) == 0) patternSelect = 3'($urandom);
      if ($urandom_range(0, 49) == 0) solidColor = 24'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 29) == 0), 11'($urandom), 11'($urandom));
    end
    check("frame_count_final", 32'(dut.frame_count), 32'(m_fc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/video_pattern_generator.md
Name: video_pattern_generator

Overview:
- Stage directly upstream of the DVI encoder. Consumes the raster timing outputs: dataEnable, hSync, vSync, hPos and vPos.
- Produces 8-bit RGB test-pattern pixels, with the sync and data-enable signals delayed to stay aligned with the pixels.
- Patterns: colour bars, checkerboard, horizontal gradient, bouncing box and solid colour. The selection is latched once per frame, so patterns never tear mid-frame.

Parameters:
- H_ACTIVE, 1280, active pixels per line; used for box bounce limits.
- V_ACTIVE, 720, active lines per frame; used for box bounce limits.
- BAR_WIDTH, 160, pixels per colour bar.
- CHECKER_SHIFT, 5, log2 of checker square size (32 px).
- GRAD_SHIFT, 2, hPos right-shift for the gradient ramp.
- BOX_SIZE, 64, box edge length in pixels.
- BOX_STEP, 4, box movement per frame in x and y, in pixels.

Ports:
- clock, in, 1, pixel clock.
- reset, in, 1, synchronous, active-high.
- dataEnable, in, 1, active-video flag from the timing generator.
- hSync, in, 1, horizontal sync, active-high.
- vSync, in, 1, vertical sync, active-high.
- hPos, in, 11, active pixel column; valid while dataEnable=1.
- vPos, in, 11, active line; valid while dataEnable=1.
- patternSelect, in, 3, requested pattern; sampled at frame start.
- solidColor, in, 24, {red,green,blue} for pattern 4; sampled at frame start.
- dataEnableOut, out, 1, dataEnable delayed 2 cycles.
- hSyncOut, out, 1, hSync delayed 2 cycles.
- vSyncOut, out, 1, vSync delayed 2 cycles.
- red, out, 8, pixel red.
- green, out, 8, pixel green.
- blue, out, 8, pixel blue.

Behaviour:
- Latency and alignment:
  - Fixed 2-cycle latency for every output; input at cycle N appears on the outputs at N+2.
  - Stage 1 registers the inputs and the bar state.
  - Stage 2 registers the RGB and the delayed control signals.
- Reset:
  - All outputs are 0.
  - Pipeline registers, activePattern, latched solid colour and frameCount are 0.
  - boxX=0, boxY=0, dirX=RIGHT, dirY=DOWN.
  - Reset mid-frame: outputs go 0 the cycle after reset is sampled. Normal output resumes 2 cycles after release, using pattern 0 until the next frame start.
- Frame start:
  - Defined as the cycle where vSync=1 and the registered previous vSync=0 (rising edge).
  - On frame start: activePattern<=patternSelect, solid<=solidColor, frameCount (16 bit) increments and wraps at 0xFFFF->0, and the box advances.
  - vSync held high for multiple cycles counts as one event.
- Blanking: when the delayed dataEnable=0, RGB=0 regardless of pattern.
- Pattern 0, colour bars:
  - barCount (8 bit) and barIndex (3 bit) clear while dataEnable=0.
  - In active video, barCount increments. When it reaches BAR_WIDTH-1 it wraps to 0 and barIndex increments, saturating at 7.
  - Colours by index 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is either 0xFF or 0x00.
- Pattern 1, checkerboard: white if hPos[CHECKER_SHIFT]^vPos[CHECKER_SHIFT]=0, otherwise black.
- Pattern 2, gradient:
  - R=G=B=hPos[GRAD_SHIFT+7:GRAD_SHIFT]; the value wraps modulo 256.
  - With defaults the ramp reaches 255 at hPos=1023, then restarts at 0.
- Pattern 3, bouncing box:
  - A pixel inside the box (boxX<=hPos<boxX+BOX_SIZE and boxY<=vPos<boxY+BOX_SIZE) is green 0x00FF00; all other active pixels are blue 0x0000FF.
  - Movement is per axis and evaluated at frame start:
    - Moving RIGHT, boxX+BOX_STEP+BOX_SIZE>H_ACTIVE: set boxX=H_ACTIVE-BOX_SIZE, dir=LEFT.
    - Moving RIGHT, otherwise: boxX+=BOX_STEP.
    - Moving LEFT, boxX<BOX_STEP: set boxX=0, dir=RIGHT.
    - Moving LEFT, otherwise: boxX-=BOX_STEP.
    - The y axis follows the same rules against V_ACTIVE, using DOWN/UP.
  - The box moves every frame whether or not pattern 3 is active.
- Pattern 4: latched solid colour.
- Patterns 5-7: black in active video.
- Arithmetic:
  - Box comparisons use 12-bit unsigned values, so boxX+BOX_SIZE cannot overflow.
  - hPos/vPos values at or beyond H_ACTIVE/V_ACTIVE are treated like any other value; no clamping.

Decomposition:
- Shared package video_pattern_pkg holds:
  - pattern code constants (PAT_BARS=0, PAT_CHECKER=1, PAT_GRADIENT=2, PAT_BOX=3, PAT_SOLID=4);
  - the 8-entry bar colour table as 24-bit constants;
  - DIR_RIGHT/LEFT and DIR_DOWN/UP encodings.
- One sub-module, bounce_axis: a single-axis position/direction register with LIMIT, SIZE and STEP parameters and a step strobe. It is instantiated twice, once per axis.

Test Plan:
- Reset held for 3 cycles mid-line with dataEnable=1 -> all outputs 0 during reset. Bars restart at white (0xFFFFFF) 2 cycles after release.
- patternSelect=0, one 1280-px line:
  - pixel at hPos=0 -> 0xFFFFFF;
  - hPos=160 -> 0xFFFF00;
  - hPos=1279 -> 0x000000;
  - each transition appears exactly 2 cycles after its input.
- patternSelect changed from 0 to 2 mid-frame -> output stays bars until the vSync rising edge. In the next frame, hPos=4 gives 0x010101 and hPos=1024 gives 0x000000.
- patternSelect=3 over 400 frames:
  - boxX goes 0,4,...,1216, holds 1216 and turns LEFT, then 1212;
  - boxY reaches 656 at frame 164, then decreases;
  - pixel (boxX,boxY) is green and (boxX+64,boxY) is blue.
- vSync held high for 5 cycles -> frameCount increments exactly once; 65536 frames wrap frameCount to 0.
- dataEnable=0 with patternSelect=4 and solidColor=0x123456 -> RGB=0. dataEnable=1 -> RGB=0x123456; hSyncOut/vSyncOut equal the inputs delayed 2 cycles.
